alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer driving an external bit-sliced ALU; shifts run one bit per cycle.
// Optional macro ALU_SEQUENCER_BACK_TO_BACK_EN lets DONE accept the next request directly.
module alu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [3:0]       ReqOp,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic [WIDTH-1:0] AluInA,
  output logic [WIDTH-1:0] AluInB,
  output logic             AluCarryIn,
  output logic             AluOr,
  output logic             AluFloodCarry,
  output logic             AluInvertA,
  output logic             AluInvertB,
  input  logic             AluCarryOut,
  input  logic [WIDTH-1:0] AluOutC
);

  localparam int unsigned SA = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [SA-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_rsp_data;
  logic              r_rsp_valid;

  logic              w_accept;
  logic [SA-1:0]     w_req_n;
  logic              w_req_shift;
  logic [WIDTH-1:0]  w_exec_result;
  logic [WIDTH-1:0]  w_shift_next;
  logic              w_last_shift;

  // A shift request with a non-zero amount goes to SHIFT; everything else takes one EXEC cycle.
  assign w_req_n      = ReqB[SA-1:0];
  assign w_req_shift  = (ReqOp == OP_SLL || ReqOp == OP_SRL || ReqOp == OP_SRA) &&
                        (w_req_n != '0);
  assign w_accept     = ReqValid && ReqReady;
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == SA'(1));

  assign RspValid = r_rsp_valid;
  assign RspData  = r_rsp_data;

  always_comb begin
    w_next_state  = r_state;
    ReqReady      = 1'b0;
    AluInA        = '0;
    AluInB        = '0;
    AluCarryIn    = 1'b0;
    AluOr         = 1'b0;
    AluFloodCarry = 1'b0;
    AluInvertA    = 1'b0;
    AluInvertB    = 1'b0;
    w_exec_result = '0;
    w_shift_next  = r_acc;

    case (r_state)
      S_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) w_next_state = w_req_shift ? S_SHIFT : S_EXEC;
      end

      S_EXEC: begin
        AluInA       = r_a;
        AluInB       = r_b;
        w_next_state = S_DONE;
        case (r_op)
          OP_ADD: w_exec_result = AluOutC;
          OP_SUB: begin
            AluInvertB    = 1'b1;
            AluCarryIn    = 1'b1;
            w_exec_result = AluOutC;
          end
          OP_AND: begin
            AluInvertA    = 1'b1;
            AluInvertB    = 1'b1;
            AluOr         = 1'b1;
            AluFloodCarry = 1'b1;
            w_exec_result = AluOutC;
          end
          OP_OR: begin
            AluOr         = 1'b1;
            w_exec_result = AluOutC;
          end
          OP_XOR: begin
            AluFloodCarry = 1'b1;
            w_exec_result = AluOutC;
          end
          OP_SLT: begin
            AluInvertB       = 1'b1;
            AluCarryIn       = 1'b1;
            // Differing signs decide directly; otherwise the difference sign cannot overflow.
            w_exec_result[0] = (r_a[WIDTH-1] != r_b[WIDTH-1]) ? r_a[WIDTH-1]
                                                              : AluOutC[WIDTH-1];
          end
          OP_SLTU: begin
            AluInvertB       = 1'b1;
            AluCarryIn       = 1'b1;
            w_exec_result[0] = ~AluCarryOut;
          end
          OP_SLL, OP_SRL, OP_SRA: begin
            AluInB        = '0;
            AluOr         = 1'b1;
            w_exec_result = r_a;
          end
          default: begin
            AluInB        = '0;
            AluOr         = 1'b1;
            w_exec_result = '0;
          end
        endcase
      end

      S_SHIFT: begin
        case (r_op)
          OP_SLL: begin
            AluInA       = r_acc;
            AluInB       = r_acc;
            w_shift_next = AluOutC;
          end
          OP_SRL:  w_shift_next = {1'b0, r_acc[WIDTH-1:1]};
          OP_SRA:  w_shift_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
          default: w_shift_next = r_acc;
        endcase
        if (r_cnt == SA'(1)) w_next_state = S_DONE;
      end

      S_DONE: begin
`ifdef ALU_SEQUENCER_BACK_TO_BACK_EN
        ReqReady = RspReady;
        if (RspReady) begin
          if (ReqValid) w_next_state = w_req_shift ? S_SHIFT : S_EXEC;
          else          w_next_state = S_IDLE;
        end
`else
        if (RspReady) w_next_state = S_IDLE;
`endif
      end

      default: w_next_state = S_IDLE;
    endcase

    // Reset silences the handshake and the external ALU in the same cycle.
    if (!RstN) begin
      w_next_state  = S_IDLE;
      ReqReady      = 1'b0;
      AluInA        = '0;
      AluInB        = '0;
      AluCarryIn    = 1'b0;
      AluOr         = 1'b0;
      AluFloodCarry = 1'b0;
      AluInvertA    = 1'b0;
      AluInvertB    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= (w_next_state == S_DONE);
      if (w_accept) begin
        r_op  <= ReqOp;
        r_a   <= ReqA;
        r_b   <= ReqB;
        r_acc <= ReqA;
        r_cnt <= w_req_n;
      end else if (r_state == S_SHIFT) begin
        r_acc <= w_shift_next;
        r_cnt <= r_cnt - SA'(1);
      end
      if (r_state == S_EXEC)  r_rsp_data <= w_exec_result;
      else if (w_last_shift)  r_rsp_data <= w_shift_next;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level model, per-cycle compare, directed vectors.
module tb_alu_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SA    = 5;
`ifdef ALU_SEQUENCER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             RstN;
  logic             ReqValid;
  logic             ReqReady;
  logic [3:0]       ReqOp;
  logic [WIDTH-1:0] ReqA;
  logic [WIDTH-1:0] ReqB;
  logic             RspValid;
  logic             RspReady;
  logic [WIDTH-1:0] RspData;
  logic [WIDTH-1:0] AluInA;
  logic [WIDTH-1:0] AluInB;
  logic             AluCarryIn;
  logic             AluOr;
  logic             AluFloodCarry;
  logic             AluInvertA;
  logic             AluInvertB;
  logic             AluCarryOut;
  logic [WIDTH-1:0] AluOutC;

  always #5 Clk = ~Clk;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .RstN(RstN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .AluInA(AluInA), .AluInB(AluInB), .AluCarryIn(AluCarryIn), .AluOr(AluOr),
    .AluFloodCarry(AluFloodCarry), .AluInvertA(AluInvertA), .AluInvertB(AluInvertB),
    .AluCarryOut(AluCarryOut), .AluOutC(AluOutC)
  );

  // External bit-sliced ALU: optional operand inversion, then add / or / xor / nor of the slices.
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH:0]   alu_sum;
  always_comb begin
    alu_a   = AluInA ^ {WIDTH{AluInvertA}};
    alu_b   = AluInB ^ {WIDTH{AluInvertB}};
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, AluCarryIn};
    AluCarryOut = 1'b0;
    if (AluOr && AluFloodCarry) AluOutC = ~(alu_a | alu_b);
    else if (AluOr)             AluOutC = alu_a | alu_b;
    else if (AluFloodCarry)     AluOutC = alu_a ^ alu_b;
    else begin
      AluOutC     = alu_sum[WIDTH-1:0];
      AluCarryOut = alu_sum[WIDTH];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_shift_op(input logic [3:0] op);
    return (op == 4'd7 || op == 4'd8 || op == 4'd9);
  endfunction

  function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    int n;
    n = int'(b[SA-1:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      4'd6: return (a < b) ? WIDTH'(1) : WIDTH'(0);
      4'd7: return a << n;
      4'd8: return a >> n;
      4'd9: return WIDTH'($signed(a) >>> n);
      default: return '0;
    endcase
  endfunction

  function automatic logic [4:0] ref_tuple(input logic [3:0] op);
    case (op)
      4'd0:             return 5'b00000;
      4'd1, 4'd5, 4'd6: return 5'b01100;
      4'd2:             return 5'b11011;
      4'd3:             return 5'b00010;
      4'd4:             return 5'b00001;
      default:          return 5'b00010;
    endcase
  endfunction

  // Transaction model: idle -> busy for lat cycles -> response held until consumed.
  bit               m_init  = 1'b0;
  bit               m_busy  = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_take;
  int               m_k, m_lat;
  logic [3:0]       m_op;
  logic [WIDTH-1:0] m_a, m_b, m_res, m_data;

  always @(posedge Clk) begin
    if (!RstN) begin
      m_init = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_data = '0; m_k = 0;
    end else if (m_init) begin
      m_take = ReqValid && !m_busy && (!m_valid || (B2B && RspReady));
      if (m_valid && RspReady) m_valid = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == m_lat) begin
          m_busy = 1'b0; m_valid = 1'b1; m_data = m_res;
        end
      end
      if (m_take) begin
        m_busy = 1'b1; m_k = 0;
        m_op = ReqOp; m_a = ReqA; m_b = ReqB;
        m_res = ref_result(ReqOp, ReqA, ReqB);
        m_lat = (is_shift_op(ReqOp) && ReqB[SA-1:0] != '0) ? int'(ReqB[SA-1:0]) : 1;
      end
    end
  end

  // Single compare process: every output checked against the model on each falling edge.
  logic             e_ready;
  logic [WIDTH-1:0] e_ina, e_inb;
  logic [4:0]       e_tuple;
  always @(negedge Clk) begin
    if (m_init) begin
      e_ready = RstN && ((!m_busy && !m_valid) || (B2B && m_valid && RspReady));
      e_ina = '0; e_inb = '0; e_tuple = 5'b00000;
      if (RstN && m_busy) begin
        if (!(is_shift_op(m_op) && m_b[SA-1:0] != '0)) begin
          e_ina   = m_a;
          e_inb   = (m_op <= 4'd6) ? m_b : '0;
          e_tuple = ref_tuple(m_op);
        end else if (m_op == 4'd7) begin
          e_ina = m_a << m_k;
          e_inb = m_a << m_k;
        end
      end
      check("ReqReady", WIDTH'(ReqReady), WIDTH'(e_ready));
      check("RspValid", WIDTH'(RspValid), WIDTH'(m_valid));
      if (m_valid) check("RspData", RspData, m_data);
      check("AluInA", AluInA, e_ina);
      check("AluInB", AluInB, e_inb);
      check("AluTuple", WIDTH'({AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFloodCarry}),
            WIDTH'(e_tuple));
    end
  end

  // Present a request and return just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    ok = 1'b0;
    ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge Clk); ok = ReqReady;
      @(posedge Clk); #1;
    end
    if (!ok) check("accept timeout", 0, 1);
    ReqValid = 1'b0; ReqOp = 4'hA; ReqA = $urandom; ReqB = $urandom;
  endtask

  task automatic wait_rsp(input string nm, input int lat, input logic [WIDTH-1:0] data);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge Clk); #1; cyc++;
      if (RspValid) break;
    end
    check($sformatf("%s latency", nm), WIDTH'(cyc), WIDTH'(lat));
    check($sformatf("%s data", nm), RspData, data);
  endtask

  task automatic release_rsp(input int hold);
    repeat (hold) begin @(posedge Clk); #1; end
    RspReady = 1'b1;
    @(posedge Clk); #1;
    RspReady = 1'b0;
  endtask

  localparam int NV = 17;
  logic [3:0]       v_op  [NV] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5,
                                   4'd6, 4'd9, 4'd8, 4'd12, 4'd8, 4'd9, 4'd7};
  logic [WIDTH-1:0] v_a   [NV] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F01234,
                                   32'hF0F01234, 32'hF0F01234, 32'd5, 32'd7, 32'd1, 32'd5,
                                   32'h80000000, 32'h12345678, 32'h12345678, 32'hF0000000,
                                   32'h7FFFFFFF, 32'd1};
  logic [WIDTH-1:0] v_b   [NV] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'h0FF0FF00, 32'h0FF0FF00,
                                   32'h0FF0FF00, 32'd7, 32'd5, 32'hFFFFFFFF, 32'd7, 32'd31,
                                   32'd0, 32'd9, 32'd4, 32'd3, 32'd31};
  int               v_lat [NV] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 31, 1, 1, 4, 3, 31};
  logic [WIDTH-1:0] v_res [NV] = '{32'h00000000, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h00F01200,
                                   32'hFFF0FF34, 32'hFF00ED34, 32'd1, 32'd0, 32'd0, 32'd1,
                                   32'hFFFFFFFF, 32'h12345678, 32'd0, 32'h0F000000,
                                   32'h0FFFFFFF, 32'h80000000};
  logic [WIDTH-1:0] sll_seq [4] = '{32'h3, 32'h6, 32'hC, 32'h18};

  initial begin
    int seen;
    RstN = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqA = '0; ReqB = '0; RspReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset RspData", RspData, 32'h0);
    check("reset RspValid", WIDTH'(RspValid), 32'h0);
    check("reset ReqReady", WIDTH'(ReqReady), 32'h0);
    RstN = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < NV; i++) begin
      send(v_op[i], v_a[i], v_b[i]);
      wait_rsp($sformatf("vec%0d op%0d", i, v_op[i]), v_lat[i], v_res[i]);
      release_rsp(i % 3);
    end

    // SLL 3 by 4: the ALU sees the accumulator doubling each cycle.
    send(4'd7, 32'h3, 32'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check($sformatf("sll AluInA step%0d", k), AluInA, sll_seq[k]);
    end
    @(posedge Clk); #1;
    check("sll RspValid at E+4", WIDTH'(RspValid), 32'h1);
    check("sll RspData", RspData, 32'h30);
    release_rsp(0);

    // Backpressure: response held 5 cycles.
    send(4'd0, 32'd2, 32'd3);
    wait_rsp("hold add", 1, 32'd5);
    release_rsp(5);
    check("after release RspValid", WIDTH'(RspValid), 32'h0);

    // Reset during the third SHIFT cycle of SRL by 10 aborts with no response.
    send(4'd8, 32'hFFFF0000, 32'd10);
    repeat (2) begin @(posedge Clk); #1; end
    RstN = 1'b0;
    @(posedge Clk); #1;
    RstN = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge Clk); #1;
      if (RspValid) seen++;
    end
    check("abort no response", WIDTH'(seen), 32'd0);
    check("abort ReqReady", WIDTH'(ReqReady), 32'h1);

    // Response completion with a new request waiting.
    send(4'd0, 32'd10, 32'd20);
    wait_rsp("b2b first", 1, 32'd30);
    ReqValid = 1'b1; ReqOp = 4'd0; ReqA = 32'd1; ReqB = 32'd2; RspReady = 1'b1;
    @(negedge Clk);
    check("DONE ReqReady", WIDTH'(ReqReady), WIDTH'(B2B));
    @(posedge Clk); #1;
    RspReady = 1'b0;
    if (!B2B) begin
      @(negedge Clk);
      check("IDLE ReqReady", WIDTH'(ReqReady), 32'h1);
      @(posedge Clk); #1;
    end
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    check("b2b second RspValid", WIDTH'(RspValid), 32'h1);
    check("b2b second RspData", RspData, 32'd3);
    release_rsp(0);

    repeat (3) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
